// File: rtl/rob_up_arb_pkg.sv
// Shared machine constants for the ROB completion-update arbiter.
// NUM_FU sets how many functional units compete for the two update ports.
package rob_up_arb_pkg;

   localparam int ROB_SZ  = 32;
   localparam int ROB_IDX = $clog2(ROB_SZ);
   localparam int PRF_IDX = 6;
   localparam int NUM_FU  = 4;
   localparam int BA_W    = 64;

   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/rob_up_arb_if.sv
// Completion requests from the functional units and the two ROB update slots.
// The ROB-side flush travels with the bus because it gates the handshake.
interface rob_up_arb_if #(
   parameter int NUM_REQ = rob_up_arb_pkg::NUM_FU,
   parameter int ROB_IDX = rob_up_arb_pkg::ROB_IDX,
   parameter int BA_W    = rob_up_arb_pkg::BA_W
);
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ-1:0]         req_ready;
   logic [NUM_REQ*ROB_IDX-1:0] req_rob_idx;
   logic [NUM_REQ*BA_W-1:0]    req_ba;
   logic [NUM_REQ-1:0]         req_bt;
   logic                       branch_miss;

   logic                       up1_req;
   logic [ROB_IDX-1:0]         rob_idx_out1;
   logic [BA_W-1:0]            ba_ex_out1;
   logic                       bt_ex_out1;
   logic                       up2_req;
   logic [ROB_IDX-1:0]         rob_idx_out2;
   logic [BA_W-1:0]            ba_ex_out2;
   logic                       bt_ex_out2;

   modport master (
      output req_valid, req_rob_idx, req_ba, req_bt, branch_miss,
      input  req_ready,
      input  up1_req, rob_idx_out1, ba_ex_out1, bt_ex_out1,
      input  up2_req, rob_idx_out2, ba_ex_out2, bt_ex_out2
   );

   modport slave (
      input  req_valid, req_rob_idx, req_ba, req_bt, branch_miss,
      output req_ready,
      output up1_req, rob_idx_out1, ba_ex_out1, bt_ex_out1,
      output up2_req, rob_idx_out2, ba_ex_out2, bt_ex_out2
   );
endinterface

// File: rtl/rob_up_arb_rr_pick2.sv
// Combinational round-robin picker returning the first two valid requesters
// found when scanning upward from the pointer with wraparound.
module rob_up_arb_rr_pick2
   import rob_up_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_FU,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant_a,
   output logic [NUM_REQ-1:0] o_grant_b,
   output logic [PTR_W-1:0]   o_idx_a,
   output logic [PTR_W-1:0]   o_idx_b,
   output logic               o_vld_a,
   output logic               o_vld_b
);

   always_comb begin
      int w_scan;
      w_scan    = 0;
      o_grant_a = '0;
      o_grant_b = '0;
      o_idx_a   = '0;
      o_idx_b   = '0;
      o_vld_a   = 1'b0;
      o_vld_b   = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_scan = (int'(i_ptr) + k) % NUM_REQ;
         if (i_valid[w_scan]) begin
            if (!o_vld_a) begin
               o_vld_a           = 1'b1;
               o_idx_a           = PTR_W'(w_scan);
               o_grant_a[w_scan] = 1'b1;
            end else if (!o_vld_b) begin
               o_vld_b           = 1'b1;
               o_idx_b           = PTR_W'(w_scan);
               o_grant_b[w_scan] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rob_up_arb.sv
// Packs up to two completing functional units per cycle into the ROB's two
// registered update slots; slot 2 is only ever filled alongside slot 1.
module rob_up_arb #(
   parameter int NUM_REQ = rob_up_arb_pkg::NUM_FU,
   parameter int ROB_IDX = rob_up_arb_pkg::ROB_IDX,
   parameter int BA_W    = rob_up_arb_pkg::BA_W
) (
   input  logic        clk,
   input  logic        reset,
   rob_up_arb_if.slave bus
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]   r_rr_ptr;
   logic               r_up1;
   logic [ROB_IDX-1:0] r_idx1;
   logic [BA_W-1:0]    r_ba1;
   logic               r_bt1;
   logic               r_up2;
   logic [ROB_IDX-1:0] r_idx2;
   logic [BA_W-1:0]    r_ba2;
   logic               r_bt2;

   logic [NUM_REQ-1:0] w_grant_a;
   logic [NUM_REQ-1:0] w_grant_b;
   logic [PTR_W-1:0]   w_sel_a;
   logic [PTR_W-1:0]   w_sel_b;
   logic               w_vld_a;
   logic               w_vld_b;
   logic [ROB_IDX-1:0] w_idx_a;
   logic [ROB_IDX-1:0] w_idx_b;
   logic [BA_W-1:0]    w_ba_a;
   logic [BA_W-1:0]    w_ba_b;
   logic               w_bt_a;
   logic               w_bt_b;

   rob_up_arb_rr_pick2 #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .i_valid   (bus.req_valid),
      .i_ptr     (r_rr_ptr),
      .o_grant_a (w_grant_a),
      .o_grant_b (w_grant_b),
      .o_idx_a   (w_sel_a),
      .o_idx_b   (w_sel_b),
      .o_vld_a   (w_vld_a),
      .o_vld_b   (w_vld_b)
   );

   // A flush squashes the handshake so no completion is consumed and then lost.
   assign bus.req_ready = (reset && !bus.branch_miss) ? (w_grant_a | w_grant_b) : '0;

   assign w_idx_a = bus.req_rob_idx[int'(w_sel_a)*ROB_IDX +: ROB_IDX];
   assign w_idx_b = bus.req_rob_idx[int'(w_sel_b)*ROB_IDX +: ROB_IDX];
   assign w_ba_a  = bus.req_ba[int'(w_sel_a)*BA_W +: BA_W];
   assign w_ba_b  = bus.req_ba[int'(w_sel_b)*BA_W +: BA_W];
   assign w_bt_a  = bus.req_bt[w_sel_a];
   assign w_bt_b  = bus.req_bt[w_sel_b];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rr_ptr <= '0;
         r_up1    <= 1'b0;
         r_idx1   <= '0;
         r_ba1    <= '0;
         r_bt1    <= 1'b0;
         r_up2    <= 1'b0;
         r_idx2   <= '0;
         r_ba2    <= '0;
         r_bt2    <= 1'b0;
      end else if (bus.branch_miss) begin
         r_rr_ptr <= '0;
         r_up1    <= 1'b0;
         r_up2    <= 1'b0;
      end else begin
         r_up1 <= w_vld_a;
         r_up2 <= w_vld_b;
         if (w_vld_a) begin
            r_idx1 <= w_idx_a;
            r_ba1  <= w_ba_a;
            r_bt1  <= w_bt_a;
         end
         if (w_vld_b) begin
            r_idx2 <= w_idx_b;
            r_ba2  <= w_ba_b;
            r_bt2  <= w_bt_b;
         end
         // Resume the scan just past the last unit served this cycle.
         if (w_vld_b)
            r_rr_ptr <= PTR_W'(rob_up_arb_pkg::wrap_inc(32'(w_sel_b), NUM_REQ));
         else if (w_vld_a)
            r_rr_ptr <= PTR_W'(rob_up_arb_pkg::wrap_inc(32'(w_sel_a), NUM_REQ));
      end
   end

   assign bus.up1_req      = r_up1;
   assign bus.rob_idx_out1 = r_idx1;
   assign bus.ba_ex_out1   = r_ba1;
   assign bus.bt_ex_out1   = r_bt1;
   assign bus.up2_req      = r_up2;
   assign bus.rob_idx_out2 = r_idx2;
   assign bus.ba_ex_out2   = r_ba2;
   assign bus.bt_ex_out2   = r_bt2;

endmodule

// File: tb/tb_rob_up_arb.sv
// Directed and randomized stimulus for rob_up_arb; expected slot contents are
// queued when a request is driven and compared one cycle later.
module tb_rob_up_arb;
   import rob_up_arb_pkg::*;

   localparam int N  = 4;
   localparam int IW = 5;
   localparam int BW = 64;

   typedef struct {
      logic          up1;
      logic [IW-1:0] idx1;
      logic [BW-1:0] ba1;
      logic          bt1;
      logic          up2;
      logic [IW-1:0] idx2;
      logic [BW-1:0] ba2;
      logic          bt2;
   } slot_t;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_fail;
   int   n_total;
   int   m_ptr;
   slot_t sb[$];

   logic [IW-1:0] pl_idx[N];
   logic [BW-1:0] pl_ba[N];
   logic          pl_bt[N];

   rob_up_arb_if #(.NUM_REQ(N), .ROB_IDX(IW), .BA_W(BW)) bus ();

   rob_up_arb #(.NUM_REQ(N), .ROB_IDX(IW), .BA_W(BW)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void pick(input logic [N-1:0] v, input int p, output int a, output int b);
      a = -1;
      b = -1;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (p + k) % N;
         if (v[j]) begin
            if (a < 0) a = j;
            else if (b < 0) b = j;
         end
      end
   endfunction

   task automatic rand_payload();
      int base;
      base = $urandom_range(0, 31);
      for (int i = 0; i < N; i++) begin
         pl_idx[i] = IW'(base + i);
         pl_ba[i]  = {$urandom, $urandom};
         pl_bt[i]  = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic check_slots();
      slot_t e;
      chk("sb_depth", 64'(sb.size()), 64'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("up1_req", bus.up1_req, e.up1);
         chk("up2_req", bus.up2_req, e.up2);
         if (e.up1) begin
            chk("rob_idx_out1", bus.rob_idx_out1, e.idx1);
            chk("ba_ex_out1", bus.ba_ex_out1, e.ba1);
            chk("bt_ex_out1", bus.bt_ex_out1, e.bt1);
         end
         if (e.up2) begin
            chk("rob_idx_out2", bus.rob_idx_out2, e.idx2);
            chk("ba_ex_out2", bus.ba_ex_out2, e.ba2);
            chk("bt_ex_out2", bus.bt_ex_out2, e.bt2);
         end
      end
      chk("up2_without_up1", bus.up2_req & ~bus.up1_req, 1'b0);
      if (bus.up2_req)
         chk("dup_rob_idx", bus.rob_idx_out1 == bus.rob_idx_out2, 1'b0);
      chk("rr_ptr", dut.r_rr_ptr, m_ptr);
   endtask

   task automatic step(input logic [N-1:0] v, input logic bm);
      int a, b;
      slot_t e;
      logic [N-1:0] exp_rdy;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         bus.req_rob_idx[i*IW +: IW] = pl_idx[i];
         bus.req_ba[i*BW +: BW]      = pl_ba[i];
         bus.req_bt[i]               = pl_bt[i];
      end
      bus.req_valid   = v;
      bus.branch_miss = bm;
      pick(v, m_ptr, a, b);
      exp_rdy = '0;
      e = '{default: '0};
      if (bm) begin
         m_ptr = 0;
      end else begin
         if (a >= 0) begin
            exp_rdy[a] = 1'b1;
            e.up1 = 1'b1; e.idx1 = pl_idx[a]; e.ba1 = pl_ba[a]; e.bt1 = pl_bt[a];
            m_ptr = (a + 1) % N;
         end
         if (b >= 0) begin
            exp_rdy[b] = 1'b1;
            e.up2 = 1'b1; e.idx2 = pl_idx[b]; e.ba2 = pl_ba[b]; e.bt2 = pl_bt[b];
            m_ptr = (b + 1) % N;
         end
      end
      sb.push_back(e);
      #1;
      chk("req_ready", bus.req_ready, exp_rdy);
      @(posedge clk);
      #1;
      check_slots();
   endtask

   initial begin
      n_pass = 0; n_fail = 0; n_total = 0; m_ptr = 0;
      rst = 1'b0;
      bus.req_valid = '0; bus.req_rob_idx = '0; bus.req_ba = '0;
      bus.req_bt = '0; bus.branch_miss = 1'b0;
      rand_payload();

      // Power-on reset with requests pending.
      #12;
      bus.req_valid = 4'b1111;
      #1;
      chk("rst_ready", bus.req_ready, 4'b0000);
      chk("rst_up1", bus.up1_req, 1'b0);
      chk("rst_up2", bus.up2_req, 1'b0);
      chk("rst_idx1", bus.rob_idx_out1, 0);
      chk("rst_ba2", bus.ba_ex_out2, 0);
      chk("rst_ptr", dut.r_rr_ptr, 0);
      @(negedge clk);
      bus.req_valid = '0;
      rst = 1'b1;

      // Single request from unit 2.
      rand_payload();
      pl_idx[2] = 5'd7; pl_ba[2] = 64'h1000; pl_bt[2] = 1'b1;
      step(4'b0100, 1'b0);

      // Flush with everyone requesting, then full load from pointer 0.
      rand_payload();
      step(4'b1111, 1'b1);
      step(4'b1111, 1'b0);
      rand_payload();
      step(4'b1111, 1'b0);

      // Wraparound from pointer 3.
      rand_payload();
      step(4'b0100, 1'b0);
      rand_payload();
      step(4'b1001, 1'b0);

      // Bring pointer to 2, then idle.
      step(4'b0010, 1'b0);
      for (int i = 0; i < 3; i++) step(4'b0000, 1'b0);

      // Randomized mix with occasional flushes.
      for (int i = 0; i < 16; i++) begin
         rand_payload();
         step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 7) == 0));
      end

      // Asynchronous reset while both slots hold updates.
      rand_payload();
      step(4'b0100, 1'b0);
      rand_payload();
      step(4'b1111, 1'b0);
      rst = 1'b0;
      #1;
      chk("mid_rst_up1", bus.up1_req, 1'b0);
      chk("mid_rst_up2", bus.up2_req, 1'b0);
      chk("mid_rst_ready", bus.req_ready, 4'b0000);
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid = '0;
      m_ptr = 0;
      #1;
      chk("post_rst_ptr", dut.r_rr_ptr, 0);
      rand_payload();
      step(4'b1111, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rob_up_arb.md
Name: rob_up_arb

Overview:
- Arbiter between the execution units and the reorder buffer's two completion-update ports.
- Each cycle it picks up to two completing functional units in round-robin order and packs them into update slot 1 and then slot 2. Slot 2 is used only when slot 1 is used, because the ROB honours update 2 only alongside update 1.
- Update outputs are registered: one cycle of latency from grant to ROB write.
- A branch-miss flush from the ROB squashes arbitration and clears the in-flight slots.

Parameters:
- NUM_REQ, 4, number of completing requesters (functional units); must be >= 2.
- ROB_IDX, `ROB_IDX, ROB index width.
- BA_W, 64, branch-address payload width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  reset, asynchronous, active-low (asserted at 0).
- req_valid  in  NUM_REQ  requester i has a completion to report.
- req_ready  out  NUM_REQ  grant to requester i; its completion is accepted this cycle.
- req_rob_idx  in  NUM_REQ*ROB_IDX  flattened ROB index per requester; requester i occupies bits [i*ROB_IDX +: ROB_IDX].
- req_ba  in  NUM_REQ*BA_W  flattened resolved branch address per requester.
- req_bt  in  NUM_REQ  resolved branch-taken bit per requester.
- branch_miss  in  1  ROB flush indication.
- up1_req  out  1  update slot 1 valid.
- rob_idx_out1  out  ROB_IDX  slot 1 ROB index.
- ba_ex_out1  out  BA_W  slot 1 branch address.
- bt_ex_out1  out  1  slot 1 taken bit.
- up2_req  out  1  update slot 2 valid.
- rob_idx_out2  out  ROB_IDX  slot 2 ROB index.
- ba_ex_out2  out  BA_W  slot 2 branch address.
- bt_ex_out2  out  1  slot 2 taken bit.

Behaviour:
- Reset (reset=0, asynchronous):
  - up1_req=0, up2_req=0; all slot payloads 0.
  - rr_ptr=0.
  - req_ready=0 while reset is asserted.
- State: rr_ptr [clog2(NUM_REQ)-1:0], plus the two registered update slots.
- Arbitration (combinational, same cycle):
  - Scan requesters in the order rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ.
  - First valid requester is grant A; second valid requester is grant B.
  - req_ready[i]=1 only for A and B. At most 2 ready bits are high per cycle.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- Accept: requester i's completion is consumed at the rising edge where req_valid[i] & req_ready[i]. The requester drops or advances its request on the next cycle.
- Slot loading (1-cycle latency):
  - A's payload goes to slot 1 (up1_req<=1).
  - B's payload goes to slot 2 (up2_req<=1).
  - No grant: up1_req<=0, up2_req<=0.
  - Only A: up2_req<=0.
  - Invariant: up2_req implies up1_req.
  - Payload registers of an invalid slot hold their previous value; only the req bits are meaningful.
- Pointer update:
  - rr_ptr <= (index of last grant this cycle + 1) mod NUM_REQ.
  - Last grant is B if present, otherwise A.
  - No grant: rr_ptr unchanged.
  - Any requester holding req_valid is granted within ceil(NUM_REQ/2) cycles.
- Flush: branch_miss=1 in a cycle forces:
  - req_ready=0 that cycle;
  - up1_req<=0 and up2_req<=0;
  - rr_ptr<=0.
  - Updates already on the outputs during the flush cycle are still written by the ROB; this is harmless because those entries are squashed.
- Duplicate ROB index in A and B is illegal, since the ROB applies slot 2 last. The bench asserts it never occurs.
- Reset asserted mid-operation clears state immediately; it does not wait for a clock edge.

Decomposition:
- Shared package / sys_defs: ROB_IDX, ROB_SZ, PRF_IDX, plus a new NUM_FU constant feeding NUM_REQ.
- No typedefs are needed; payloads stay flattened vectors.
- One natural sub-module, rr_pick2: a combinational two-grant round-robin picker.
  - Inputs: valid vector, pointer.
  - Outputs: grant_a/grant_b one-hot, their indices, and valid flags.
- rob_up_arb wraps rr_pick2 with the pointer register, payload muxes, output registers and flush logic.

Test Plan (NUM_REQ=4, ROB_IDX=5):
- Reset: drive reset=0 mid-cycle with slots valid -> up1_req=up2_req=0 immediately, req_ready=0; after release, rr_ptr=0.
- Single request: req_valid=0100, idx2=7, ba2=0x1000, bt2=1 -> req_ready=0100 same cycle. Next cycle: up1_req=1, rob_idx_out1=7, ba_ex_out1=0x1000, bt_ex_out1=1, up2_req=0; rr_ptr=3.
- Full load, rr_ptr=0, req_valid held at 1111:
  - Cycle 1: req_ready=0011; then slot1=req0, slot2=req1; rr_ptr=2.
  - Cycle 2: req_ready=1100; slot1=req2, slot2=req3; rr_ptr=0.
- Wrap: rr_ptr=3, req_valid=1001 -> slot1=req3, slot2=req0, rr_ptr=1; up2_req never high without up1_req.
- Flush: req_valid=1111 with branch_miss=1 -> req_ready=0000; next cycle up1_req=up2_req=0, rr_ptr=0. The following cycle with branch_miss=0 grants req0 and req1.
- Idle/hold: req_valid=0000 for 3 cycles after rr_ptr=2 -> up1_req=up2_req=0, rr_ptr stays 2.
